// File: rtl/keccak_dom_pkg.sv
// Shared constants and index helpers for the DOM-masked Keccak chi datapath.
package keccak_dom_pkg;

   localparam int ROW_W = 5;

   // Index of the fresh-randomness word shared by the cross terms (i,j) and (j,i).
   function automatic int pair_idx(input int i, input int j);
      int lo;
      int hi;
      lo = (i < j) ? i : j;
      hi = (i < j) ? j : i;
      return lo + hi * (hi - 1) / 2;
   endfunction

   function automatic int nz(input int shares, input int less_rand);
      return shares * (shares - 1) / 2 - less_rand;
   endfunction

   function automatic int term_idx(input int i, input int j, input int shares);
      return i * shares + j;
   endfunction

endpackage

// File: rtl/keccak_chi_dom_row.sv
// Combinational DOM term generator for one 5-bit chi row: SHARES*SHARES terms per bit.
module keccak_chi_dom_row
   import keccak_dom_pkg::*;
#(
   parameter int SHARES    = 3,
   parameter int LESS_RAND = 0,
   parameter int IOTA_EN   = 1,
   parameter int ROWS      = 8,
   parameter int ROW_IDX   = 0,
   localparam int NZ       = nz(SHARES, LESS_RAND),
   localparam int ZN       = (NZ > 0) ? NZ : 1
) (
   input  logic [SHARES*ROW_W-1:0]        shares,
   input  logic [ZN*ROW_W-1:0]            z,
   input  logic [ROWS-1:0]                rc,
   output logic [SHARES*SHARES*ROW_W-1:0] terms
);

   logic [ROW_W-1:0] s [SHARES];
   logic             rc_bit;
   logic             unused_rc;
   logic             unused_z;

   for (genvar gs = 0; gs < SHARES; gs++) begin : g_s
      assign s[gs] = shares[gs*ROW_W +: ROW_W];
   end

   assign rc_bit    = (IOTA_EN != 0) ? rc[ROW_IDX] : 1'b0;
   assign unused_rc = ^rc;
   assign unused_z  = ^z;

   for (genvar gi = 0; gi < SHARES; gi++) begin : g_i
      for (genvar gj = 0; gj < SHARES; gj++) begin : g_j
         for (genvar gx = 0; gx < ROW_W; gx++) begin : g_x
            localparam int X1 = (gx + 1) % ROW_W;
            localparam int X2 = (gx + 2) % ROW_W;
            localparam int T  = term_idx(gi, gj, SHARES) * ROW_W + gx;
            if (gi == gj) begin : g_inner
               // With reduced randomness the last two shares get S[x0] via their cross term.
               if (LESS_RAND != 0 && gi >= SHARES - 2) begin : g_drop
                  assign terms[T] = ~s[gi][X1] & s[gi][X2];
               end else begin : g_full
                  assign terms[T] = s[gi][gx] ^ (~s[gi][X1] & s[gi][X2]);
               end
            end else begin : g_cross
               localparam int P = pair_idx(gi, gj);
               logic mask;
               if (LESS_RAND != 0 && P == NZ) begin : g_self
                  assign mask = s[gi][gx];
               end else begin : g_fresh
                  assign mask = z[P*ROW_W + gx];
               end
               if (gi == 0 && gj == 1 && gx == 0) begin : g_iota
                  assign terms[T] = (s[gi][X1] & s[gj][X2]) ^ mask ^ rc_bit;
               end else begin : g_plain
                  assign terms[T] = (s[gi][X1] & s[gj][X2]) ^ mask;
               end
            end
         end
      end
   end

endmodule

// File: rtl/keccak_chi_dom_stream.sv
// Two-stage streaming DOM-masked chi(+iota): registered terms, then registered share compression.
module keccak_chi_dom_stream
   import keccak_dom_pkg::*;
#(
   parameter int SHARES    = 3,
   parameter int ROWS      = 8,
   parameter int LESS_RAND = 0,
   parameter int IOTA_EN   = 1,
   localparam int NZ       = nz(SHARES, LESS_RAND),
   localparam int ZN       = (NZ > 0) ? NZ : 1,
   localparam int W        = SHARES * ROWS * ROW_W
) (
   input  logic                      ClkxCI,
   input  logic                      RstxRI,
   input  logic                      InValidxSI,
   output logic                      InReadyxSO,
   input  logic [W-1:0]              InputxDI,
   input  logic [ROWS-1:0]           IotaRCxDI,
   input  logic [ZN*ROWS*ROW_W-1:0]  ZxDI,
   input  logic                      ZValidxSI,
   output logic                      ZReadyxSO,
   output logic                      OutValidxSO,
   input  logic                      OutReadyxSI,
   output logic [W-1:0]              OutputxDO
);

   localparam int NT = SHARES * SHARES;
   localparam int TW = NT * ROW_W;

   logic                 s1_valid_reg;
   logic                 s2_valid_reg;
   logic [TW*ROWS-1:0]   term_next;
   logic [TW*ROWS-1:0]   term_reg;
   logic [W-1:0]         out_next;
   logic [W-1:0]         out_reg;
   logic                 s2_load;
   logic                 in_ready;
   logic                 accept;

   for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
      logic [SHARES*ROW_W-1:0] row_shares;
      logic [ZN*ROW_W-1:0]     row_z;
      for (genvar gs = 0; gs < SHARES; gs++) begin : g_s
         assign row_shares[gs*ROW_W +: ROW_W] = InputxDI[(gs*ROWS + gr)*ROW_W +: ROW_W];
      end
      for (genvar gp = 0; gp < ZN; gp++) begin : g_p
         assign row_z[gp*ROW_W +: ROW_W] = ZxDI[(gp*ROWS + gr)*ROW_W +: ROW_W];
      end
      keccak_chi_dom_row #(
         .SHARES    (SHARES),
         .LESS_RAND (LESS_RAND),
         .IOTA_EN   (IOTA_EN),
         .ROWS      (ROWS),
         .ROW_IDX   (gr)
      ) u_row (
         .shares (row_shares),
         .z      (row_z),
         .rc     (IotaRCxDI),
         .terms  (term_next[gr*TW +: TW])
      );
   end

   // Compression reads only registered terms so glitches cannot combine unmasked values.
   always_comb begin
      out_next = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
               out_next[(i*ROWS + r)*ROW_W +: ROW_W] ^=
                  term_reg[(r*NT + term_idx(i, j, SHARES))*ROW_W +: ROW_W];
            end
         end
      end
   end

   assign s2_load  = s1_valid_reg & (~s2_valid_reg | OutReadyxSI);
   assign in_ready = ZValidxSI & (~s1_valid_reg | s2_load);
   assign accept   = InValidxSI & in_ready;

   always_ff @(posedge ClkxCI) begin
      if (RstxRI) begin
         s1_valid_reg <= 1'b0;
         s2_valid_reg <= 1'b0;
         term_reg     <= '0;
         out_reg      <= '0;
      end else begin
         if (accept) begin
            term_reg <= term_next;
         end
         if (s2_load) begin
            out_reg <= out_next;
         end
         s1_valid_reg <= accept | (s1_valid_reg & ~s2_load);
         s2_valid_reg <= s2_load | (s2_valid_reg & ~OutReadyxSI);
      end
   end

   assign InReadyxSO  = in_ready;
   assign ZReadyxSO   = accept;
   assign OutValidxSO = s2_valid_reg;
   assign OutputxDO   = out_reg;

endmodule

// File: tb/tb_keccak_chi_dom_stream.sv
// Directed and randomised-mask checks of two configurations of the masked chi stream.
module tb_keccak_chi_dom_stream;

   localparam int SA = 3, RA = 2, NZA = 2;
   localparam int SB = 2, RB = 1, NZB = 1;
   localparam int WA = SA*RA*5, ZWA = NZA*RA*5;
   localparam int WB = SB*RB*5, ZWB = NZB*RB*5;

   logic clk = 1'b0;
   logic srst;
   always #5 clk = ~clk;

   logic            in_valid, z_valid, out_ready;
   logic [WA-1:0]   in_a, out_a;
   logic [RA-1:0]   rc_a;
   logic [ZWA-1:0]  z_a;
   logic            in_ready_a, z_ready_a, out_valid_a;
   logic [WB-1:0]   in_b, out_b;
   logic [RB-1:0]   rc_b;
   logic [ZWB-1:0]  z_b;
   logic            in_ready_b, z_ready_b, out_valid_b;

   keccak_chi_dom_stream #(.SHARES(SA), .ROWS(RA), .LESS_RAND(1), .IOTA_EN(1)) u_dut_a (
      .ClkxCI(clk), .RstxRI(srst), .InValidxSI(in_valid), .InReadyxSO(in_ready_a),
      .InputxDI(in_a), .IotaRCxDI(rc_a), .ZxDI(z_a), .ZValidxSI(z_valid),
      .ZReadyxSO(z_ready_a), .OutValidxSO(out_valid_a), .OutReadyxSI(out_ready),
      .OutputxDO(out_a)
   );

   keccak_chi_dom_stream #(.SHARES(SB), .ROWS(RB), .LESS_RAND(0), .IOTA_EN(0)) u_dut_b (
      .ClkxCI(clk), .RstxRI(srst), .InValidxSI(in_valid), .InReadyxSO(in_ready_b),
      .InputxDI(in_b), .IotaRCxDI(rc_b), .ZxDI(z_b), .ZValidxSI(z_valid),
      .ZReadyxSO(z_ready_b), .OutValidxSO(out_valid_b), .OutReadyxSI(out_ready),
      .OutputxDO(out_b)
   );

   int n_cmp = 0;
   int n_err = 0;
   int n_pop = 0;
   logic [14:0] sb [$];
   logic [14:0] cur_exp;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [4:0] chi5(input logic [4:0] a);
      logic [4:0] r;
      for (int x = 0; x < 5; x++) r[x] = a[x] ^ (~a[(x+1)%5] & a[(x+2)%5]);
      return r;
   endfunction

   function automatic logic [9:0] xor_a(input logic [WA-1:0] o);
      logic [9:0] r;
      r = '0;
      for (int s = 0; s < SA; s++)
         for (int rr = 0; rr < RA; rr++) r[rr*5 +: 5] ^= o[(s*RA + rr)*5 +: 5];
      return r;
   endfunction

   function automatic logic [4:0] xor_b(input logic [WB-1:0] o);
      return o[4:0] ^ o[9:5];
   endfunction

   // Present one beat: unmasked rows are split into random shares when masked is set.
   task automatic set_beat(input logic [4:0] u0, input logic [4:0] u1, input logic [4:0] ub,
                           input logic [1:0] rca, input logic rcb,
                           input logic [9:0] ea, input logic [4:0] eb, input bit masked);
      logic [4:0] m1, m2, u;
      for (int r = 0; r < RA; r++) begin
         m1 = masked ? 5'($urandom) : 5'd0;
         m2 = masked ? 5'($urandom) : 5'd0;
         u  = (r == 0) ? u0 : u1;
         in_a[(0*RA + r)*5 +: 5] = u ^ m1 ^ m2;
         in_a[(1*RA + r)*5 +: 5] = m1;
         in_a[(2*RA + r)*5 +: 5] = m2;
      end
      m1 = masked ? 5'($urandom) : 5'd0;
      in_b = {m1, ub ^ m1};
      z_a  = masked ? ZWA'($urandom) : '0;
      z_b  = masked ? ZWB'($urandom) : '0;
      rc_a = rca;
      rc_b = rcb;
      cur_exp = {eb, ea};
   endtask

   task automatic rand_beat();
      logic [4:0] u0, u1, ub;
      logic [1:0] rca;
      u0  = 5'($urandom);
      u1  = 5'($urandom);
      ub  = 5'($urandom);
      rca = 2'($urandom);
      set_beat(u0, u1, ub, rca, 1'($urandom),
               {chi5(u1) ^ {4'b0, rca[1]}, chi5(u0) ^ {4'b0, rca[0]}}, chi5(ub), 1'b1);
   endtask

   // One clock: observe handshakes at the falling edge, return just after the rising edge.
   task automatic cycle(output bit acc);
      logic [14:0] e;
      @(negedge clk);
      acc = in_valid && in_ready_a;
      if (out_valid_a && out_ready) begin
         n_pop++;
         if (sb.size() == 0) begin
            check("spurious_pop", 32'd1, 32'd0);
         end else begin
            e = sb.pop_front();
            $display("beat %0d: a=%h (exp %h) b=%h (exp %h)", n_pop, xor_a(out_a), e[9:0],
                     xor_b(out_b), e[14:10]);
            check("out_a_xor", 32'(xor_a(out_a)), 32'(e[9:0]));
            check("out_b_xor", 32'(xor_b(out_b)), 32'(e[14:10]));
            check("out_valid_b", 32'(out_valid_b), 32'd1);
         end
      end
      if (acc) sb.push_back(cur_exp);
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n_acc, sent, cyc, p0;
      srst = 1'b1; in_valid = 1'b0; z_valid = 1'b0; out_ready = 1'b0;
      set_beat(5'd0, 5'd0, 5'd0, 2'd0, 1'b0, 10'd0, 5'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      srst = 1'b0;
      check("rst_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_out_b", 32'(out_b), 32'd0);

      // Randomness gating, then the unmasked single-beat latency vector.
      in_valid = 1'b1;
      set_beat(5'b10110, 5'b00001, 5'b10110, 2'b01, 1'b1,
               {5'b01001, 5'b00011}, 5'b00010, 1'b0);
      #1;
      check("noz_in_ready", 32'(in_ready_a), 32'd0);
      check("noz_z_ready", 32'(z_ready_a), 32'd0);
      cycle(acc);
      check("noz_accept", 32'(acc), 32'd0);
      z_valid = 1'b1;
      #1;
      check("z_in_ready", 32'(in_ready_a), 32'd1);
      check("z_z_ready", 32'(z_ready_a), 32'd1);
      out_ready = 1'b1;
      cycle(acc);
      in_valid = 1'b0;
      check("lat1_valid", 32'(out_valid_a), 32'd0);
      cycle(acc);
      check("lat2_valid", 32'(out_valid_a), 32'd1);
      cycle(acc);

      // Backpressure: stall output, exactly two beats fit.
      out_ready = 1'b0; in_valid = 1'b1;
      set_beat(5'b00010, 5'b11111, 5'b00001, 2'b10, 1'b1,
               {5'b11110, 5'b10010}, 5'b01001, 1'b1);
      n_acc = 0;
      for (int k = 0; k < 4; k++) begin
         cycle(acc);
         if (acc) begin
            n_acc++;
            if (n_acc == 1)
               set_beat(5'b00000, 5'b10110, 5'b00010, 2'b00, 1'b0,
                        {5'b00010, 5'b00000}, 5'b10010, 1'b1);
            else
               set_beat(5'b11111, 5'b00010, 5'b11111, 2'b11, 1'b1,
                        {5'b10011, 5'b11110}, 5'b11111, 1'b1);
         end
         if (k == 1) check("full_hold_a1", 32'(xor_a(out_a)), 32'(10'b11110_10010));
      end
      check("full_accepts", 32'(n_acc), 32'd2);
      check("full_in_ready", 32'(in_ready_a), 32'd0);
      check("full_valid", 32'(out_valid_a), 32'd1);
      check("full_hold_a2", 32'(xor_a(out_a)), 32'(10'b11110_10010));

      // Release: pop and accept in the same cycle, then drain one beat per cycle.
      out_ready = 1'b1;
      p0 = n_pop;
      cycle(acc);
      check("resume_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      cycle(acc);
      cycle(acc);
      check("resume_pops", 32'(n_pop - p0), 32'd3);

      // Random masks, randomness and handshakes.
      sent = 0; cyc = 0;
      rand_beat();
      while (sent < 150 && cyc < 3000) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         z_valid   = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 9) < 7);
         cycle(acc);
         cyc++;
         if (acc) begin
            sent++;
            if (sent < 150) rand_beat();
         end
      end
      check("rand_sent", 32'(sent), 32'd150);
      in_valid = 1'b0; out_ready = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) cycle(acc);
      check("rand_drain", 32'(sb.size()), 32'd0);

      // Reset with two beats in flight.
      z_valid = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      rand_beat();
      cycle(acc);
      rand_beat();
      cycle(acc);
      srst = 1'b1; in_valid = 1'b0;
      cycle(acc);
      check("midrst_valid", 32'(out_valid_a), 32'd0);
      check("midrst_out_a", 32'(out_a), 32'd0);
      check("midrst_out_b", 32'(out_b), 32'd0);
      srst = 1'b0;
      sb.delete();
      set_beat(5'b10110, 5'b00001, 5'b10110, 2'b01, 1'b1,
               {5'b01001, 5'b00011}, 5'b00010, 1'b1);
      in_valid = 1'b1; out_ready = 1'b1;
      cycle(acc);
      check("postrst_accept", 32'(acc), 32'd1);
      in_valid = 1'b0;
      check("postrst_lat1", 32'(out_valid_a), 32'd0);
      cycle(acc);
      check("postrst_lat2", 32'(out_valid_a), 32'd1);
      p0 = n_pop;
      cycle(acc);
      check("postrst_pop", 32'(n_pop - p0), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
